m3_step_seq: RTL and testbench

Parametrised step sequencer for the three-phase motor path. Generates the electrical step index and step/round strobes, with a configurable number of steps per round. Ramps the step period toward a target by a fixed fraction per round. Also handles direction, soft stop, hard stop and a saturating power level. Sits between the operator command inputs and the phase/PWM generators, which consume stepO, stepStrobeO and powerO.

---
 rtl/m3_step_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_m3_step_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_step_seq.sv
// m3_step_seq
// Step sequencer for the three-phase motor path. It produces the electrical
// step index and the step/round strobes. At each round end it ramps the step
// period toward a goal by a fixed fraction. It also handles direction, soft
// stop, hard stop and a saturating power level.
//
// Ports
//   clkI          system clock
//   rstI          asynchronous active-high reset
//   startI        level, run request
//   forceStopI    level, immediate stop (highest priority)
//   invRotateI    direction, 1 = reverse; latched when leaving IDLE
//   dstPeriodI    target step period; sampled when leaving IDLE
//   speedINCi     one-cycle pulse, shortens the target period
//   speedDECi     one-cycle pulse, lengthens the target period
//   powerINCi     one-cycle pulse, raises power
//   powerDECi     one-cycle pulse, lowers power
//   stepO         current step index
//   stepStrobeO   high for the first cycle of a new step index
//   roundStrobeO  high together with stepStrobeO when the index wraps
//   periodO       current step period in clock cycles
//   powerO        power level
//   workingO      state != IDLE
//   stateO        IDLE=0, ACCEL=1, RUN=2, DECEL=3
`timescale 1ns/1ps

module m3_step_seq #(
  parameter int STEPS      = 12,
  parameter int PW         = 22,
  parameter int PERIOD_MIN = 40,
  parameter int PERIOD_MAX = 4000000,
  parameter int RAMP_SH    = 4,
  parameter int PWRW       = 10,
  parameter int POWER_INIT = 100,
  parameter int POWER_STEP = 10,
  parameter int POWER_MAX  = 1000
) (
  input  logic                     clkI,
  input  logic                     rstI,
  input  logic                     startI,
  input  logic                     forceStopI,
  input  logic                     invRotateI,
  input  logic [PW-1:0]            dstPeriodI,
  input  logic                     speedINCi,
  input  logic                     speedDECi,
  input  logic                     powerINCi,
  input  logic                     powerDECi,
  output logic [$clog2(STEPS)-1:0] stepO,
  output logic                     stepStrobeO,
  output logic                     roundStrobeO,
  output logic [PW-1:0]            periodO,
  output logic [PWRW-1:0]          powerO,
  output logic                     workingO,
  output logic [1:0]               stateO
);

  localparam int SW = $clog2(STEPS);

  localparam logic [PW-1:0]   P_MIN     = PW'(PERIOD_MIN);
  localparam logic [PW-1:0]   P_MAX     = PW'(PERIOD_MAX);
  localparam logic [PW-1:0]   P_ONE     = PW'(1);
  localparam logic [SW-1:0]   STEP_LAST = SW'(STEPS - 1);
  localparam logic [SW-1:0]   STEP_ONE  = SW'(1);
  localparam logic [PWRW-1:0] PWR_INIT  = PWRW'(POWER_INIT);
  localparam logic [PWRW-1:0] PWR_STEP  = PWRW'(POWER_STEP);
  localparam logic [PWRW-1:0] PWR_MAX   = PWRW'(POWER_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_RUN   = 2'd2,
    ST_DECEL = 2'd3
  } state_t;

  // All sequencer state in one record, so that reset and hard stop load the
  // same constant.
  typedef struct packed {
    state_t          state;
    logic [SW-1:0]   step;
    logic [PW-1:0]   period;
    logic [PW-1:0]   remain;   // cycles left until the next step advance
    logic [PW-1:0]   tgt;      // ramp goal while accelerating / running
    logic [PWRW-1:0] power;
    logic            dir;      // 1 = reverse
    logic            step_strobe;
    logic            round_strobe;
  } seq_regs_t;

  localparam seq_regs_t SEQ_RESET = '{
    state:        ST_IDLE,
    step:         '0,
    period:       P_MAX,
    remain:       P_MAX,
    tgt:          P_MAX,
    power:        '0,
    dir:          1'b0,
    step_strobe:  1'b0,
    round_strobe: 1'b0
  };

  seq_regs_t r_seq;

  logic            w_working;
  logic            w_advance;
  logic            w_wrap;
  logic            w_round_end;
  logic [SW-1:0]   w_step_next;
  logic [PW-1:0]   w_goal;
  logic [PW-1:0]   w_ramp_d;
  logic [PW-1:0]   w_period_upd;
  logic [PW-1:0]   w_reload;
  logic [PW-1:0]   w_tgt_d;
  logic [PW-1:0]   w_tgt_inc;
  logic [PW-1:0]   w_tgt_dec;
  logic [PW-1:0]   w_dst_clamped;
  logic [PWRW-1:0] w_power_inc;
  logic [PWRW-1:0] w_power_dec;

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_working   = (r_seq.state != ST_IDLE);
    w_advance   = w_working && (r_seq.remain == P_ONE);
    w_wrap      = 1'b0;
    w_step_next = r_seq.step;
    if (r_seq.dir) begin
      w_wrap      = (r_seq.step == '0);
      w_step_next = w_wrap ? STEP_LAST : r_seq.step - STEP_ONE;
    end else begin
      w_wrap      = (r_seq.step == STEP_LAST);
      w_step_next = w_wrap ? '0 : r_seq.step + STEP_ONE;
    end
    w_round_end = w_advance && w_wrap;

    // Ramp: move by max(1, period>>RAMP_SH) toward the goal without
    // overshooting. Differences are taken first, so nothing underflows.
    w_goal   = (r_seq.state == ST_DECEL) ? P_MAX : r_seq.tgt;
    w_ramp_d = r_seq.period >> RAMP_SH;
    if (w_ramp_d == '0) w_ramp_d = P_ONE;
    w_period_upd = r_seq.period;
    if (r_seq.period > w_goal) begin
      w_period_upd = ((r_seq.period - w_goal) >= w_ramp_d) ?
                     r_seq.period - w_ramp_d : w_goal;
    end else if (r_seq.period < w_goal) begin
      w_period_upd = ((w_goal - r_seq.period) >= w_ramp_d) ?
                     r_seq.period + w_ramp_d : w_goal;
    end
    // The reload at a round end already uses the freshly ramped period.
    w_reload = w_round_end ? w_period_upd : r_seq.period;

    // Target adjust, clamped to [P_MIN, P_MAX]; tgt never leaves that range.
    w_tgt_d = r_seq.tgt >> RAMP_SH;
    if (w_tgt_d == '0) w_tgt_d = P_ONE;
    w_tgt_inc = ((r_seq.tgt - P_MIN) >= w_tgt_d) ? r_seq.tgt - w_tgt_d : P_MIN;
    w_tgt_dec = ((P_MAX - r_seq.tgt) >= w_tgt_d) ? r_seq.tgt + w_tgt_d : P_MAX;

    w_dst_clamped = dstPeriodI;
    if (dstPeriodI < P_MIN)      w_dst_clamped = P_MIN;
    else if (dstPeriodI > P_MAX) w_dst_clamped = P_MAX;

    w_power_inc = ((PWR_MAX - r_seq.power) >= PWR_STEP) ?
                  r_seq.power + PWR_STEP : PWR_MAX;
    w_power_dec = (r_seq.power >= PWR_STEP) ? r_seq.power - PWR_STEP : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before this edge. A later
  // assignment to the same field in this block overrides an earlier one.
  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      r_seq <= SEQ_RESET;
    end else if (forceStopI) begin
      r_seq <= SEQ_RESET;
    end else begin
      case (r_seq.state)
        ST_IDLE: begin
          r_seq.step_strobe  <= 1'b0;
          r_seq.round_strobe <= 1'b0;
          if (startI) begin
            r_seq.state <= ST_ACCEL;
            r_seq.tgt   <= w_dst_clamped;
            r_seq.dir   <= invRotateI;
            r_seq.power <= PWR_INIT;
          end
        end

        default: begin
          r_seq.step_strobe  <= w_advance;
          r_seq.round_strobe <= w_round_end;
          r_seq.remain       <= w_advance ? w_reload : r_seq.remain - P_ONE;
          if (w_advance)   r_seq.step   <= w_step_next;
          if (w_round_end) r_seq.period <= w_period_upd;

          // Speed commands only act while accelerating or running.
          if ((r_seq.state != ST_DECEL) && (speedINCi ^ speedDECi))
            r_seq.tgt <= speedINCi ? w_tgt_inc : w_tgt_dec;

          if (powerINCi ^ powerDECi)
            r_seq.power <= powerINCi ? w_power_inc : w_power_dec;

          case (r_seq.state)
            ST_ACCEL: begin
              if (!startI)
                r_seq.state <= ST_DECEL;
              else if (w_round_end && (w_period_upd == r_seq.tgt))
                r_seq.state <= ST_RUN;
            end
            ST_RUN: begin
              if (!startI) r_seq.state <= ST_DECEL;
            end
            ST_DECEL: begin
              if (startI) begin
                r_seq.state <= ST_ACCEL;
              end else if (w_round_end && (w_period_upd == P_MAX)) begin
                // Back to rest: idle values except dir and tgt.
                r_seq.state  <= ST_IDLE;
                r_seq.step   <= '0;
                r_seq.remain <= P_MAX;
                r_seq.power  <= '0;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign stepO        = r_seq.step;
  assign stepStrobeO  = r_seq.step_strobe;
  assign roundStrobeO = r_seq.round_strobe;
  assign periodO      = r_seq.period;
  assign powerO       = r_seq.power;
  assign workingO     = w_working;
  assign stateO       = r_seq.state;

endmodule

// File: tb/tb_m3_step_seq.sv
// Self-checking bench for m3_step_seq with STEPS=12, PERIOD_MAX=300,
// PERIOD_MIN=40, RAMP_SH=2. Outputs are sampled on the falling clock edge,
// and inputs are driven there.
`timescale 1ns/1ps

module tb_m3_step_seq;

  logic        clk = 1'b0;
  logic        rstI;
  logic        startI;
  logic        forceStopI;
  logic        invRotateI;
  logic [21:0] dstPeriodI;
  logic        speedINCi;
  logic        speedDECi;
  logic        powerINCi;
  logic        powerDECi;
  logic [3:0]  stepO;
  logic        stepStrobeO;
  logic        roundStrobeO;
  logic [21:0] periodO;
  logic [9:0]  powerO;
  logic        workingO;
  logic [1:0]  stateO;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_ACCEL = 2'd1, S_RUN = 2'd2, S_DECEL = 2'd3;

  typedef struct {
    int         period;   // periodO right after the round end
    logic [1:0] state;    // stateO right after the round end
  } round_vec_t;

  typedef struct {
    int   n;              // number of one-cycle pulses
    logic inc;
    logic dec;
    int   power;          // expected powerO after the pulses
  } power_vec_t;

  m3_step_seq #(
    .STEPS(12), .PW(22), .PERIOD_MIN(40), .PERIOD_MAX(300), .RAMP_SH(2),
    .PWRW(10), .POWER_INIT(100), .POWER_STEP(10), .POWER_MAX(1000)
  ) dut (
    .clkI(clk), .rstI(rstI), .startI(startI), .forceStopI(forceStopI),
    .invRotateI(invRotateI), .dstPeriodI(dstPeriodI),
    .speedINCi(speedINCi), .speedDECi(speedDECi),
    .powerINCi(powerINCi), .powerDECi(powerDECi),
    .stepO(stepO), .stepStrobeO(stepStrobeO), .roundStrobeO(roundStrobeO),
    .periodO(periodO), .powerO(powerO), .workingO(workingO), .stateO(stateO)
  );

  always #500 clk = ~clk;

  initial begin
    #60_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rest(input string name);
    check({name, "_state"},   32'(stateO),       32'(S_IDLE));
    check({name, "_step"},    32'(stepO),        32'd0);
    check({name, "_period"},  32'(periodO),      32'd300);
    check({name, "_power"},   32'(powerO),       32'd0);
    check({name, "_working"}, 32'(workingO),     32'd0);
    check({name, "_sstb"},    32'(stepStrobeO),  32'd0);
    check({name, "_rstb"},    32'(roundStrobeO), 32'd0);
  endtask

  // Counts falling edges until a step strobe is seen (bounded).
  task automatic wait_step(input string name, input int max_cycles, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (stepStrobeO !== 1'b1 && gap < max_cycles);
    check({name, "_strobe"}, 32'(stepStrobeO), 32'd1);
  endtask

  task automatic step_check(input string name, input int exp_gap,
                            input int exp_step, input logic exp_round);
    int gap;
    wait_step(name, exp_gap + 20, gap);
    check({name, "_gap"},   32'(gap),          32'(exp_gap));
    check({name, "_step"},  32'(stepO),        32'(exp_step));
    check({name, "_round"}, 32'(roundStrobeO), 32'(exp_round));
  endtask

  // Waits for a round end (or the drop to IDLE at the end of a decel).
  task automatic wait_round(input string name, input int max_cycles);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (roundStrobeO !== 1'b1 && stateO !== S_IDLE && cyc < max_cycles);
    check({name, "_reached"}, 32'(roundStrobeO || (stateO == S_IDLE)), 32'd1);
  endtask

  task automatic pulse(input logic s_inc, input logic s_dec,
                       input logic p_inc, input logic p_dec);
    speedINCi = s_inc; speedDECi = s_dec; powerINCi = p_inc; powerDECi = p_dec;
    @(negedge clk);
    speedINCi = 1'b0; speedDECi = 1'b0; powerINCi = 1'b0; powerDECi = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    round_vec_t acc_tbl[4];
    round_vec_t dec_tbl[5];
    round_vec_t spd_tbl[7];
    power_vec_t pwr_tbl[9];
    int gap_exp;

    acc_tbl[0] = '{225, S_ACCEL};
    acc_tbl[1] = '{169, S_ACCEL};
    acc_tbl[2] = '{127, S_ACCEL};
    acc_tbl[3] = '{100, S_RUN};

    dec_tbl[0] = '{125, S_DECEL};
    dec_tbl[1] = '{156, S_DECEL};
    dec_tbl[2] = '{195, S_DECEL};
    dec_tbl[3] = '{243, S_DECEL};
    dec_tbl[4] = '{300, S_IDLE};

    // Target 20 clamps to 40; one speedDEC then makes it 50.
    spd_tbl[0] = '{225, S_ACCEL};
    spd_tbl[1] = '{169, S_ACCEL};
    spd_tbl[2] = '{127, S_ACCEL};
    spd_tbl[3] = '{96,  S_ACCEL};
    spd_tbl[4] = '{72,  S_ACCEL};
    spd_tbl[5] = '{54,  S_ACCEL};
    spd_tbl[6] = '{50,  S_RUN};

    pwr_tbl[0] = '{91, 1'b1, 1'b0, 1000};
    pwr_tbl[1] = '{3,  1'b1, 1'b0, 1000};
    pwr_tbl[2] = '{2,  1'b1, 1'b1, 1000};
    pwr_tbl[3] = '{1,  1'b0, 1'b1, 990};
    pwr_tbl[4] = '{89, 1'b0, 1'b1, 100};
    pwr_tbl[5] = '{2,  1'b1, 1'b1, 100};
    pwr_tbl[6] = '{11, 1'b0, 1'b1, 0};
    pwr_tbl[7] = '{1,  1'b0, 1'b1, 0};
    pwr_tbl[8] = '{1,  1'b1, 1'b0, 10};

    rstI = 1'b1; startI = 1'b0; forceStopI = 1'b0; invRotateI = 1'b0;
    dstPeriodI = 22'd0; speedINCi = 1'b0; speedDECi = 1'b0;
    powerINCi = 1'b0; powerDECi = 1'b0;

    repeat (3) @(negedge clk);
    check_rest("reset");
    rstI = 1'b0;
    @(negedge clk);
    check("idle_hold_state", 32'(stateO), 32'(S_IDLE));

    // ---- forward acceleration to RUN at 100, then soft stop ----
    startI = 1'b1; dstPeriodI = 22'd100; invRotateI = 1'b0;
    @(negedge clk);
    check("fwd_entry_state",   32'(stateO),   32'(S_ACCEL));
    check("fwd_entry_power",   32'(powerO),   32'd100);
    check("fwd_entry_period",  32'(periodO),  32'd300);
    check("fwd_entry_working", 32'(workingO), 32'd1);

    gap_exp = 300;
    for (int r = 0; r < 4; r++) begin
      for (int k = 1; k <= 12; k++)
        step_check($sformatf("acc_r%0d_k%0d", r, k), gap_exp, k % 12, k == 12);
      check($sformatf("acc_r%0d_period", r), 32'(periodO), 32'(acc_tbl[r].period));
      check($sformatf("acc_r%0d_state", r),  32'(stateO),  32'(acc_tbl[r].state));
      gap_exp = acc_tbl[r].period;
    end
    step_check("run_gap", 100, 1, 1'b0);

    startI = 1'b0;
    @(negedge clk);
    check("soft_stop_state", 32'(stateO), 32'(S_DECEL));
    for (int r = 0; r < 5; r++) begin
      wait_round($sformatf("dec_r%0d", r), 12 * 300 + 50);
      check($sformatf("dec_r%0d_period", r), 32'(periodO), 32'(dec_tbl[r].period));
      check($sformatf("dec_r%0d_state", r),  32'(stateO),  32'(dec_tbl[r].state));
    end
    check("dec_end_working", 32'(workingO), 32'd0);
    check("dec_end_step",    32'(stepO),    32'd0);
    check("dec_end_power",   32'(powerO),   32'd0);

    // ---- reverse direction; toggling invRotateI mid-run is ignored ----
    startI = 1'b1; dstPeriodI = 22'd100; invRotateI = 1'b1;
    @(negedge clk);
    check("rev_entry_state", 32'(stateO), 32'(S_ACCEL));
    step_check("rev_s1", 300, 11, 1'b1);
    check("rev_s1_period", 32'(periodO), 32'd225);
    step_check("rev_s2", 225, 10, 1'b0);
    invRotateI = 1'b0;
    step_check("rev_s3", 225, 9, 1'b0);
    step_check("rev_s4", 225, 8, 1'b0);

    // ---- hard stop mid-step ----
    repeat (50) @(negedge clk);
    forceStopI = 1'b1;
    @(negedge clk);
    check_rest("hard_stop");
    repeat (5) @(negedge clk);
    check("force_hold_state",   32'(stateO),   32'(S_IDLE));
    check("force_hold_working", 32'(workingO), 32'd0);
    forceStopI = 1'b0;
    @(negedge clk);
    check("force_release_state", 32'(stateO), 32'(S_ACCEL));

    // ---- asynchronous reset mid-ACCEL, seen before the next clock edge ----
    repeat (20) @(negedge clk);
    #100 rstI = 1'b1;
    #1 check_rest("async_reset");
    @(negedge clk);
    startI = 1'b0;
    @(negedge clk);
    rstI = 1'b0;
    @(negedge clk);
    check("post_reset_state", 32'(stateO), 32'(S_IDLE));

    // ---- speed commands with clamping, power table, ramp to new target ----
    startI = 1'b1; dstPeriodI = 22'd20; invRotateI = 1'b0;
    @(negedge clk);
    check("spd_entry_state", 32'(stateO), 32'(S_ACCEL));
    check("spd_entry_power", 32'(powerO), 32'd100);
    repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < pwr_tbl[v].n; i++)
        pulse(1'b0, 1'b0, pwr_tbl[v].inc, pwr_tbl[v].dec);
      check($sformatf("pwr_v%0d", v), 32'(powerO), 32'(pwr_tbl[v].power));
    end

    for (int r = 0; r < 7; r++) begin
      wait_round($sformatf("spd_r%0d", r), 12 * 300 + 50);
      check($sformatf("spd_r%0d_period", r), 32'(periodO), 32'(spd_tbl[r].period));
      check($sformatf("spd_r%0d_state", r),  32'(stateO),  32'(spd_tbl[r].state));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
